// File: rtl/add_round_key_serial.sv
`default_nettype none
// ============================================================================
//  Module      : add_round_key_serial
//  Description : Lane-serial AddRoundKey engine for the AES-128 datapath.
//                Holds a small round-key file. It accepts a state block plus
//                a key index, XORs the state with the selected round key
//                LANE_W bits per cycle, and presents the result on a
//                valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_round_key_serial #(
  parameter  int BLOCK_W  = 128,
  parameter  int LANE_W   = 32,
  parameter  int NUM_KEYS = 11,
  localparam int BEATS    = BLOCK_W / LANE_W,
  localparam int KIDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_wr_en,
  input  logic [KIDX_W-1:0]  key_wr_idx,
  input  logic [BLOCK_W-1:0] key_wr_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_state,
  input  logic [KIDX_W-1:0]  in_key_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_state,
  output logic               out_err,
  output logic               busy
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [1:0]         r_state;
  logic [BEAT_W-1:0]  r_beat;
  logic [BLOCK_W-1:0] r_work;
  logic [BLOCK_W-1:0] r_wkey;
  logic               r_err;
  logic [BLOCK_W-1:0] r_key_mem [NUM_KEYS];

  logic               w_accept;
  logic               w_idx_ok;
  logic               w_wr_ok;
  logic               w_last_beat;
  logic [BLOCK_W-1:0] w_key_sel;
  logic [BLOCK_W-1:0] w_work_next;

  // Ready is decoded from state; in DONE it follows out_ready so a new block
  // can be taken on the same edge the finished one is handed off.
  assign in_ready = (r_state == c_IDLE) || ((r_state == c_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // Index range checks are done at 32 bits so they stay correct when
  // NUM_KEYS is an exact power of two.
  assign w_idx_ok = (32'(in_key_idx) < 32'(NUM_KEYS));
  assign w_wr_ok  = (32'(key_wr_idx) < 32'(NUM_KEYS));

  // An out-of-range index snapshots zeros, so the block passes through
  // unchanged and is flagged through out_err.
  assign w_key_sel   = w_idx_ok ? r_key_mem[in_key_idx] : '0;
  assign w_last_beat = (r_beat == c_LAST_BEAT);

  // Only the lane addressed by the beat counter is XORed this cycle.
  // All other lanes pass through unchanged.
  for (genvar i = 0; i < BEATS; i++) begin : g_lane
    assign w_work_next[i*LANE_W +: LANE_W] =
      (r_beat == BEAT_W'(i)) ? (r_work[i*LANE_W +: LANE_W] ^ r_wkey[i*LANE_W +: LANE_W])
                             :  r_work[i*LANE_W +: LANE_W];
  end : g_lane

  // Key file: writable in any state. Because the snapshot below samples the
  // pre-edge contents, a same-edge write is not seen by the accepted block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_key_mem[k] <= '0;
      end
    end else if (key_wr_en && w_wr_ok) begin
      r_key_mem[key_wr_idx] <= key_wr_data;
    end
  end

  // Control FSM and working registers. The key is snapshotted at accept, so
  // later key-file writes cannot disturb an in-flight block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_beat  <= '0;
      r_work  <= '0;
      r_wkey  <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_state <= c_RUN;
      r_beat  <= '0;
      r_work  <= in_state;
      r_wkey  <= w_key_sel;
      r_err   <= !w_idx_ok;
    end else begin
      case (r_state)
        c_RUN: begin
          r_work <= w_work_next;
          if (w_last_beat) begin
            r_state <= c_DONE;
            r_beat  <= '0;
          end else begin
            r_beat  <= r_beat + 1'b1;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        c_IDLE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // The working register is only modified in RUN, so it is a stable result
  // for as long as the FSM sits in DONE.
  assign out_valid = (r_state == c_DONE);
  assign out_state = r_work;
  assign out_err   = r_err;
  assign busy      = (r_state != c_IDLE);

endmodule : add_round_key_serial
`default_nettype wire

// File: tb/tb_add_round_key_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_round_key_serial
//  Description : Scoreboard bench for add_round_key_serial. A reference model
//                predicts each result at accept time. A separate monitor
//                checks outputs, latency and stability under backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_round_key_serial;

  localparam int BW    = 128;
  localparam int LW    = 32;
  localparam int NK    = 11;
  localparam int KW    = 4;
  localparam int BEATS = BW / LW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_wr_en;
  logic [KW-1:0] key_wr_idx;
  logic [BW-1:0] key_wr_data;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_state;
  logic [KW-1:0] in_key_idx;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_state;
  logic          out_err;
  logic          busy;

  // Auxiliary instances with other lane widths share the key/state inputs.
  logic          in_valid_x;
  logic          in_ready8, in_ready128;
  logic          out_valid8, out_valid128;
  logic [BW-1:0] out_state8, out_state128;
  logic          out_err8, out_err128, busy8, busy128;
  logic          out_ready_x = 1'b1;

  always #5 clk = ~clk;

  add_round_key_serial #(.BLOCK_W(BW), .LANE_W(LW), .NUM_KEYS(NK)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key_idx(in_key_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .out_err(out_err), .busy(busy)
  );

  add_round_key_serial #(.BLOCK_W(BW), .LANE_W(8), .NUM_KEYS(NK)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid_x), .in_ready(in_ready8),
    .in_state(in_state), .in_key_idx(in_key_idx), .out_valid(out_valid8),
    .out_ready(out_ready_x), .out_state(out_state8), .out_err(out_err8), .busy(busy8)
  );

  add_round_key_serial #(.BLOCK_W(BW), .LANE_W(128), .NUM_KEYS(NK)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid_x), .in_ready(in_ready128),
    .in_state(in_state), .in_key_idx(in_key_idx), .out_valid(out_valid128),
    .out_ready(out_ready_x), .out_state(out_state128), .out_err(out_err128), .busy(busy128)
  );

  typedef struct {
    logic [BW-1:0] st;
    logic          err;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  logic [BW-1:0] m_key [16];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [BW-1:0] last_out = '0;
  logic          last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the result is the state XOR the key as it stood before
  // the accepting edge, or the unchanged state with err when the index is
  // outside the key file. Writes to indices outside the file are dropped.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      for (int k = 0; k < 16; k++) m_key[k] = '0;
    end else begin
      if (in_valid && in_ready) begin
        e.err = (in_key_idx >= KW'(NK));
        e.st  = e.err ? in_state : (in_state ^ m_key[in_key_idx]);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      if (key_wr_en && key_wr_idx < KW'(NK)) m_key[key_wr_idx] = key_wr_data;
    end
  end

  // Monitor: pops on each output handshake, checks latency on the rising
  // edge of out_valid and stability while the consumer stalls.
  logic          pv = 1'b0, pr = 1'b0, pe = 1'b0;
  logic [BW-1:0] ps = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", BW'(out_valid), BW'(1'b1));
        chk("hold_state", out_state, ps);
        chk("hold_err", BW'(out_err), BW'(pe));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", BW'(out_valid), BW'(1'b0));
        end else begin
          if (!pv) chk("latency", BW'(cyc - sb[0].acc), BW'(BEATS));
          if (!out_ready) chk("in_ready_stalled", BW'(in_ready), BW'(1'b0));
          if (out_ready) begin
            e = sb.pop_front();
            chk("out_state", out_state, e.st);
            chk("out_err", BW'(out_err), BW'(e.err));
            last_out = out_state;
            last_err = out_err;
          end
        end
      end
      pv = out_valid; pr = out_ready; ps = out_state; pe = out_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [KW-1:0] idx, input logic [BW-1:0] data);
    key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = data;
    tick();
    key_wr_en = 1'b0;
  endtask

  task automatic issue(input logic [BW-1:0] st, input logic [KW-1:0] idx);
    bit ok = 1'b0;
    in_state = st; in_key_idx = idx; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    tick();
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", BW'(ok), BW'(1'b1));
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0 && !out_valid) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("drain_timeout", BW'(sb.size()), BW'(0));
  endtask

  function automatic logic [BW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [BW-1:0] c_K0  = 128'hac19285777fad15c66dc2900f321415a;
  localparam logic [BW-1:0] c_S0  = 128'hc9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9;
  localparam logic [BW-1:0] c_R0  = 128'h65d0e19ebe331895af15e0c93ae88893;

  bit rdone;

  initial begin
    logic [BW-1:0] s, ka, kb, k3;
    int lat8, lat128;
    logic [BW-1:0] r8, r128;

    rst_n = 1'b0; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    in_valid = 1'b0; in_state = '0; in_key_idx = '0; out_ready = 1'b1;
    in_valid_x = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", BW'(in_ready), BW'(1'b1));
    chk("rst_out_valid", BW'(out_valid), BW'(1'b0));
    chk("rst_out_state", out_state, '0);
    chk("rst_out_err", BW'(out_err), BW'(1'b0));
    chk("rst_busy", BW'(busy), BW'(1'b0));
    rst_n = 1'b1;
    tick();

    // Known-answer vector at LANE_W = 32.
    wr_key(0, c_K0);
    issue(c_S0, 0);
    drain();
    chk("kat_state", last_out, c_R0);
    chk("kat_err", BW'(last_err), BW'(1'b0));

    // Same vector at LANE_W = 8 and 128.
    in_state = c_S0; in_key_idx = 0; in_valid_x = 1'b1;
    tick();
    in_valid_x = 1'b0;
    lat8 = -1; lat128 = -1; r8 = '0; r128 = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid8 && lat8 < 0) begin lat8 = k; r8 = out_state8; end
      if (out_valid128 && lat128 < 0) begin lat128 = k; r128 = out_state128; end
    end
    chk("lane8_latency", BW'(lat8), BW'(16));
    chk("lane8_state", r8, c_R0);
    chk("lane128_latency", BW'(lat128), BW'(1));
    chk("lane128_state", r128, c_R0);

    // Backpressure, then back-to-back accept with the output handshake.
    out_ready = 1'b0;
    issue(rnd128(), 0);
    for (int k = 0; k < 50 && !out_valid; k++) tick();
    repeat (5) tick();
    chk("stall_in_ready", BW'(in_ready), BW'(1'b0));
    out_ready = 1'b1;
    issue(rnd128(), 0);
    drain();

    // Key write on the accept edge and again during RUN.
    k3 = rnd128(); ka = rnd128(); kb = rnd128(); s = rnd128();
    wr_key(3, k3);
    in_state = s; in_key_idx = 3; in_valid = 1'b1;
    key_wr_en = 1'b1; key_wr_idx = 3; key_wr_data = ka;
    tick();
    in_valid = 1'b0; key_wr_data = kb;
    tick();
    key_wr_en = 1'b0;
    drain();
    chk("wr_race_old_key", last_out, s ^ k3);
    issue(s, 3);
    drain();
    chk("wr_newest_key", last_out, s ^ kb);

    // Out-of-range index and an ignored out-of-range write.
    s = rnd128();
    issue(s, 12);
    drain();
    chk("oor_state", last_out, s);
    chk("oor_err", BW'(last_err), BW'(1'b1));
    wr_key(15, rnd128());
    for (int i = 0; i < 16; i++) issue(rnd128(), KW'(i));
    drain();

    // Randomised traffic with random backpressure and key writes.
    rdone = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          if ($urandom_range(0, 2) == 0) wr_key(KW'($urandom_range(0, 15)), rnd128());
          issue(rnd128(), KW'($urandom_range(0, 15)));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset during beat 2 of RUN discards the block and clears the keys.
    issue(rnd128(), 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", BW'(out_valid), BW'(1'b0));
    chk("midrst_in_ready", BW'(in_ready), BW'(1'b1));
    chk("midrst_busy", BW'(busy), BW'(1'b0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NK; i++) issue('0, KW'(i));
    drain();
    chk("post_rst_key_zero", last_out, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_add_round_key_serial
`default_nettype wire
